// File: rtl/reaction_timer_ctrl.sv
// Reaction-time measurement controller: random pre-stimulus delay, LED stimulus,
// millisecond reaction count, false-start and timeout detection for a 7-segment driver.
module reaction_timer_ctrl #(
    parameter int TICKS_PER_MS = 10000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int DELAY_MASK   = 2047,
    parameter int MAX_MS       = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn,
    output logic        led,
    output logic [13:0] value,
    output logic        show_error,
    output logic        result_valid,
    output logic        busy
);

    localparam int          PW     = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [13:0] MIN_D  = 14'(MIN_DELAY_MS);
    localparam logic [11:0] MASK12 = 12'(DELAY_MASK);
    localparam logic [13:0] MAX_C  = 14'(MAX_MS);

    typedef enum logic [2:0] {IDLE, DELAY, REACT, RESULT, ERROR} state_t;

    state_t        state, state_next;
    logic          s1, s2, s3;
    logic          press;
    logic [15:0]   lfsr;
    logic [PW-1:0] prescaler;
    logic          tick;
    logic [13:0]   dly, dly_next, dly_load;
    logic [13:0]   cnt, cnt_next;
    logic [13:0]   value_next;
    logic          valid_next;

    // s1/s2 resolve metastability on the raw button; s3 gives the rising-edge detect.
    assign press    = s2 & ~s3;
    assign tick     = (prescaler == PW'(TICKS_PER_MS - 1));
    assign dly_load = MIN_D + 14'(lfsr[11:0] & MASK12);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_next = state;
        dly_next   = dly;
        cnt_next   = cnt;
        value_next = value;
        valid_next = 1'b0;
        case (state)
            IDLE: begin
                if (press) begin
                    state_next = DELAY;
                    dly_next   = dly_load;
                end
            end
            DELAY: begin
                // A press on the final tick is still a false start.
                if (press) begin
                    state_next = ERROR;
                    value_next = '0;
                end else if (tick) begin
                    if (dly <= 14'd1) begin
                        state_next = REACT;
                        cnt_next   = '0;
                    end else begin
                        dly_next = dly - 14'd1;
                    end
                end
            end
            REACT: begin
                // Timeout wins over a press landing on the same tick.
                if (tick && (cnt == MAX_C - 14'd1)) begin
                    state_next = ERROR;
                    value_next = '0;
                end else if (press) begin
                    state_next = RESULT;
                    value_next = cnt;
                    valid_next = 1'b1;
                end else if (tick) begin
                    cnt_next = cnt + 14'd1;
                end
            end
            RESULT, ERROR: begin
                if (press) begin
                    state_next = DELAY;
                    dly_next   = dly_load;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            lfsr         <= 16'hACE1;
            prescaler    <= '0;
            dly          <= '0;
            cnt          <= '0;
            value        <= '0;
            led          <= 1'b0;
            show_error   <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s1    <= btn;
            s2    <= s1;
            s3    <= s2;
            lfsr  <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            state <= state_next;
            if (state_next != state || tick)
                prescaler <= '0;
            else
                prescaler <= prescaler + PW'(1);
            dly          <= dly_next;
            cnt          <= cnt_next;
            value        <= value_next;
            result_valid <= valid_next;
            // Outputs decoded from the next state so they are registered yet aligned with it.
            led          <= (state_next == REACT);
            show_error   <= (state_next == ERROR);
            busy         <= (state_next == DELAY) || (state_next == REACT);
        end
    end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Scoreboard bench for reaction_timer_ctrl: stimulus pushes expected LED/result/error
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_reaction_timer_ctrl;

    localparam int T     = 4;
    localparam int MIN   = 3;
    localparam int MASK  = 3;
    localparam int MAXMS = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn;
    logic        led;
    logic [13:0] value;
    logic        show_error;
    logic        result_valid;
    logic        busy;

    reaction_timer_ctrl #(
        .TICKS_PER_MS(T),
        .MIN_DELAY_MS(MIN),
        .DELAY_MASK  (MASK),
        .MAX_MS      (MAXMS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .led         (led),
        .value       (value),
        .show_error  (show_error),
        .result_valid(result_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSR, used only to predict the random delay of each trial.
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= lfsr_step(m_lfsr);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef enum {EV_LED, EV_RES, EV_ERR} ev_t;
    typedef struct {
        ev_t   kind;
        int    data;
        string name;
    } exp_t;
    exp_t sb[$];

    task automatic push(input ev_t k, input int d, input string n);
        exp_t e;
        e.kind = k;
        e.data = d;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic observe(input ev_t k, input int d);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s: got data %0d expected no event", k.name(), d);
        end else begin
            e = sb.pop_front();
            check({e.name, "_kind"}, k, e.kind);
            check(e.name, d, e.data);
        end
    endtask

    logic prev_led = 1'b0;
    logic prev_err = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (led && !prev_led)        observe(EV_LED, cyc);
            if (result_valid)            observe(EV_RES, int'(value));
            if (show_error && !prev_err) observe(EV_ERR, int'(value));
            if (led && show_error)       check("led_and_error_exclusive", 1, 0);
        end
        prev_led = led;
        prev_err = show_error;
    end

    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Button rises just after edge c; the FSM acts on it at edge c+3. Held 4 cycles.
    task automatic pulse_btn(input int c);
        goto_cycle(c);
        btn = 1'b1;
        goto_cycle(c + 4);
        btn = 1'b0;
    endtask

    // Same as pulse_btn, also returning the delay (ms) the trial will draw.
    task automatic start_trial(input int c, output int d);
        goto_cycle(c);
        d = MIN + int'(lfsr_step(lfsr_step(m_lfsr)) & 16'(MASK));
        btn = 1'b1;
        goto_cycle(c + 4);
        btn = 1'b0;
    endtask

    initial begin
        int c, d, e, r;
        reset = 1'b1;
        btn   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_led", led, 0);
        check("rst_busy", busy, 0);
        check("rst_show_error", show_error, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_value", value, 0);
        @(negedge clk) reset = 1'b0;

        // 1: idle with button low
        goto_cycle(cyc + 100);
        check("idle_led", led, 0);
        check("idle_busy", busy, 0);
        check("idle_show_error", show_error, 0);
        check("idle_value", value, 0);

        // 2: normal trial, press after 7 ticks
        c = cyc + 2;
        start_trial(c, d);
        e = c + 3;
        r = e + 4 * d;
        push(EV_LED, r, "t2_led_rise");
        goto_cycle(c + 5);
        check("t2_busy_in_delay", busy, 1);
        check("t2_led_off_in_delay", led, 0);
        push(EV_RES, 7, "t2_result");
        pulse_btn(r + 27);
        goto_cycle(r + 31);
        check("t2_led_after", led, 0);
        check("t2_value_held", value, 7);
        check("t2_valid_one_cycle", result_valid, 0);
        check("t2_busy_after", busy, 0);

        // 3: false start two ticks into DELAY
        c = cyc + 8;
        start_trial(c, d);
        e = c + 3;
        goto_cycle(c + 5);
        check("t3_value_kept_in_delay", value, 7);
        push(EV_ERR, 0, "t3_false_start");
        pulse_btn(e + 7);
        goto_cycle(e + 11);
        check("t3_show_error", show_error, 1);
        check("t3_value_cleared", value, 0);
        check("t3_led", led, 0);

        // 4: timeout after MAXMS ticks in REACT
        c = cyc + 8;
        start_trial(c, d);
        e = c + 3;
        r = e + 4 * d;
        push(EV_LED, r, "t4_led_rise");
        push(EV_ERR, 0, "t4_timeout");
        goto_cycle(r + 79);
        check("t4_led_before_timeout", led, 1);
        check("t4_no_error_before_timeout", show_error, 0);
        goto_cycle(r + 80);
        check("t4_show_error", show_error, 1);
        check("t4_led_off", led, 0);

        // 5a: press from ERROR restarts, then collide with the final DELAY tick
        c = r + 88;
        start_trial(c, d);
        check("t4_restart_busy", busy, 1);
        check("t4_restart_error_clear", show_error, 0);
        push(EV_ERR, 0, "t5_final_tick_collision");
        pulse_btn(c + 4 * d);
        check("t5_collision_error", show_error, 1);
        check("t5_collision_led", led, 0);

        // 5b: press on the REACT tick taking cnt from 5 to 6
        c = cyc + 8;
        start_trial(c, d);
        e = c + 3;
        r = e + 4 * d;
        push(EV_LED, r, "t5_led_rise");
        push(EV_RES, 5, "t5_tick_collision");
        pulse_btn(r + 21);
        goto_cycle(r + 26);
        check("t5_value", value, 5);
        check("t5_led_off", led, 0);

        // 6: asynchronous reset mid-REACT
        c = cyc + 8;
        start_trial(c, d);
        e = c + 3;
        r = e + 4 * d;
        push(EV_LED, r, "t6_led_rise");
        goto_cycle(r + 10);
        check("t6_led_in_react", led, 1);
        check("t6_busy_in_react", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_led", led, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_value", value, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        goto_cycle(cyc + 5);
        check("t6_post_busy", busy, 0);
        check("t6_post_led", led, 0);
        check("t6_post_show_error", show_error, 0);
        c = cyc + 2;
        pulse_btn(c);
        check("t6_idle_to_delay", busy, 1);

        goto_cycle(cyc + 5);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
